// File: rtl/bram_arb_pkg.sv
// Shared defaults and helpers for the BRAM port arbiter.
//
// Contents:
//   NReqDef, AddrWidthDef, DataWidthDef, IdxWDef : default parameter values
//   addr_conflict()                              : same-address hazard check between two requests
package bram_arb_pkg;

    localparam int unsigned NReqDef      = 4;
    localparam int unsigned AddrWidthDef = 5;
    localparam int unsigned DataWidthDef = 10;
    localparam int unsigned IdxWDef      = 2;

    // Addresses are passed zero-extended to 32 bits so the helper is width-agnostic.
    // Two reads of the same address are harmless; any write on a shared address is a hazard.
    function automatic logic addr_conflict(input logic [31:0] addr_a,
                                           input logic [31:0] addr_b,
                                           input logic        we_a,
                                           input logic        we_b);
        return (addr_a == addr_b) && (we_a || we_b);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first requester, scanning from 'start' upward modulo N,
// whose request bit is set and whose exclude bit is clear.
//
// Ports:
//   req_mask  in  N      candidate requests
//   start     in  IDX_W  first index in scan order
//   exclude   in  N      requesters that must be skipped
//   grant     out N      one-hot winner (all zero if none)
//   idx       out IDX_W  index of the winner (0 if none)
//   found     out 1      a winner exists
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req_mask,
    input  logic [IDX_W-1:0] start,
    input  logic [N-1:0]     exclude,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        int unsigned j;
        j     = 0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(start) + k) % N;
            if (!found && req_mask[j] && !exclude[j]) begin
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Arbitrates N_REQ requesters onto the two ports of a dual-port RAM. Up to two requests are
// granted per cycle in round-robin order; port 2 never takes a request that hazards with the
// port 1 request. Read data returns to the originating requester one cycle after the grant.
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   req_valid/we/addr/wdata per-requester request (addr/wdata flattened, requester i at slice i)
//   req_ready               per-requester grant (combinational)
//   rsp_valid/rsp_data      per-requester read response (one-cycle pulse)
//   ram_addr*/we*/data*     RAM port drive
//   ram_out1/ram_out2       RAM registered read data
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = NReqDef,
    parameter int unsigned ADDR_WIDTH = AddrWidthDef,
    parameter int unsigned DATA_WIDTH = DataWidthDef,
    parameter int unsigned IDX_W      = IdxWDef
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [N_REQ*DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0]       ram_addr1,
    output logic [ADDR_WIDTH-1:0]       ram_addr2,
    output logic                        ram_we1,
    output logic                        ram_we2,
    output logic [DATA_WIDTH-1:0]       ram_data1,
    output logic [DATA_WIDTH-1:0]       ram_data2,
    input  logic [DATA_WIDTH-1:0]       ram_out1,
    input  logic [DATA_WIDTH-1:0]       ram_out2
);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             p1_vld_q, p2_vld_q;
    logic [IDX_W-1:0] p1_idx_q, p2_idx_q;

    logic [N_REQ-1:0] grant1, grant2, excl2, conflict;
    logic [IDX_W-1:0] idx1, idx2;
    logic             found1, found2;

    logic [ADDR_WIDTH-1:0] addr1, addr2;
    logic [DATA_WIDTH-1:0] wdata1, wdata2;
    logic                  we1, we2;
    logic                  gnt1, gnt2;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick1 (
        .req_mask (req_valid),
        .start    (rr_ptr_q),
        .exclude  ({N_REQ{1'b0}}),
        .grant    (grant1),
        .idx      (idx1),
        .found    (found1)
    );

    assign addr1  = req_addr[int'(idx1)*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata1 = req_wdata[int'(idx1)*DATA_WIDTH +: DATA_WIDTH];
    assign we1    = req_we[idx1];

    // Anything hazarding with the port 1 winner is invisible to port 2 this cycle.
    always_comb begin
        conflict = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            conflict[i] = addr_conflict(32'(req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]), 32'(addr1),
                                        req_we[i], we1);
        end
    end

    assign excl2 = grant1 | conflict;

    // Starting at rr_ptr is equivalent to starting after the port 1 winner: every requester
    // scanned before it is invalid.
    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick2 (
        .req_mask (req_valid),
        .start    (rr_ptr_q),
        .exclude  (excl2),
        .grant    (grant2),
        .idx      (idx2),
        .found    (found2)
    );

    assign addr2  = req_addr[int'(idx2)*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata2 = req_wdata[int'(idx2)*DATA_WIDTH +: DATA_WIDTH];
    assign we2    = req_we[idx2];

    // Reset forces all grants and RAM strobes low combinationally.
    assign gnt1 = reset & found1;
    assign gnt2 = reset & found2;

    assign req_ready = reset ? (grant1 | grant2) : '0;

    assign ram_we1   = gnt1 & we1;
    assign ram_addr1 = gnt1 ? addr1 : '0;
    assign ram_data1 = gnt1 ? wdata1 : '0;
    assign ram_we2   = gnt2 & we2;
    assign ram_addr2 = gnt2 ? addr2 : '0;
    assign ram_data2 = gnt2 ? wdata2 : '0;

    // Next priority starts just past the last requester served.
    always_comb begin
        logic [IDX_W-1:0] last;
        last     = found2 ? idx2 : idx1;
        rr_ptr_d = rr_ptr_q;
        if (found1) begin
            rr_ptr_d = IDX_W'((32'(last) + 1) % N_REQ);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            p1_vld_q <= 1'b0;
            p1_idx_q <= '0;
            p2_vld_q <= 1'b0;
            p2_idx_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            p1_vld_q <= found1 & ~we1;
            p1_idx_q <= idx1;
            p2_vld_q <= found2 & ~we2;
            p2_idx_q <= idx2;
        end
    end

    // The two tags never name the same requester, so the writes below never collide.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (p1_vld_q) begin
            rsp_valid[p1_idx_q]                               = 1'b1;
            rsp_data[int'(p1_idx_q)*DATA_WIDTH +: DATA_WIDTH] = ram_out1;
        end
        if (p2_vld_q) begin
            rsp_valid[p2_idx_q]                               = 1'b1;
            rsp_data[int'(p2_idx_q)*DATA_WIDTH +: DATA_WIDTH] = ram_out2;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata, rsp_data;
    logic [AW-1:0]   ram_addr1, ram_addr2;
    logic            ram_we1, ram_we2;
    logic [DW-1:0]   ram_data1, ram_data2, ram_out1, ram_out2;

    bram_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .ram_addr1 (ram_addr1),
        .ram_addr2 (ram_addr2),
        .ram_we1   (ram_we1),
        .ram_we2   (ram_we2),
        .ram_data1 (ram_data1),
        .ram_data2 (ram_data2),
        .ram_out1  (ram_out1),
        .ram_out2  (ram_out2)
    );

    always #5 clk = ~clk;

    // Dual-port RAM stand-in with registered outputs.
    logic [DW-1:0] ram_mem [32] = '{default: '0};
    always @(posedge clk) begin
        if (ram_we1) ram_mem[ram_addr1] <= ram_data1;
        if (ram_we2) ram_mem[ram_addr2] <= ram_data2;
        ram_out1 <= ram_mem[ram_addr1];
        ram_out2 <= ram_mem[ram_addr2];
    end

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] shadow [32] = '{default: '0};
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_we[i]            = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    // Pop and compare one scoreboard entry per asserted rsp_valid bit.
    task automatic check_rsp();
        for (int i = 0; i < N; i++) begin
            if (rsp_valid[i]) begin
                int k;
                k = -1;
                for (int e = 0; e < sb.size(); e++) begin
                    if (k < 0 && sb[e].idx == i) k = e;
                end
                if (k < 0) begin
                    chk("rsp_spurious", 32'(rsp_valid[i]), 32'd0);
                end else begin
                    chk("rsp_data", 32'(rsp_data[i*DW +: DW]), 32'(sb[k].data));
                    sb.delete(k);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_rsp();
    endtask

    // Check the expected grant vector, record expected read data and shadow writes, advance.
    task automatic grant(input string tag, input logic [N-1:0] exp_ready);
        exp_t e;
        #1;
        chk(tag, 32'(req_ready), 32'(exp_ready));
        for (int i = 0; i < N; i++) begin
            if (exp_ready[i] && !req_we[i]) begin
                e.idx  = i;
                e.data = shadow[req_addr[i*AW +: AW]];
                sb.push_back(e);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (exp_ready[i] && req_we[i]) shadow[req_addr[i*AW +: AW]] = req_wdata[i*DW +: DW];
        end
        tick();
    endtask

    initial begin
        logic [N-1:0] exp_pair;

        // Reset held with every requester valid.
        clear_reqs();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(10 + i), '0);
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_we1", 32'(ram_we1), 32'd0);
        chk("rst_we2", 32'(ram_we2), 32'd0);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_addr1", 32'(ram_addr1), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        grant("release_ready", 4'b0011);
        chk("release_rsp", 32'(rsp_valid), 32'b0011);
        #1;
        chk("release_ptr2", 32'(req_ready), 32'b1100);
        clear_reqs();
        tick();
        chk("idle_rsp", 32'(rsp_valid), 32'd0);

        // Write then read back through one requester.
        set_req(2, 1'b1, 1'b1, 5'd7, 10'h155);
        #1;
        chk("wr_we1", 32'(ram_we1), 32'd1);
        chk("wr_addr1", 32'(ram_addr1), 32'd7);
        chk("wr_data1", 32'(ram_data1), 32'h155);
        chk("wr_we2", 32'(ram_we2), 32'd0);
        grant("wr_ready", 4'b0100);
        set_req(2, 1'b1, 1'b0, 5'd7, '0);
        grant("rd_ready", 4'b0100);
        chk("rd_rsp", 32'(rsp_valid), 32'b0100);
        clear_reqs();
        tick();
        chk("wr_no_rsp", 32'(rsp_valid), 32'd0);

        // Two writes to different addresses, then dual read.
        set_req(0, 1'b1, 1'b1, 5'd3, 10'h0AA);
        set_req(3, 1'b1, 1'b1, 5'd9, 10'h3FF);
        grant("preload", 4'b1001);
        clear_reqs();
        set_req(0, 1'b1, 1'b0, 5'd3, '0);
        set_req(3, 1'b1, 1'b0, 5'd9, '0);
        grant("dual_rd", 4'b1001);
        chk("dual_rsp", 32'(rsp_valid), 32'b1001);

        // Bring rr_ptr to 0 by serving requester 3 alone.
        clear_reqs();
        set_req(3, 1'b1, 1'b0, 5'd20, '0);
        grant("align", 4'b1000);
        chk("align_rsp", 32'(rsp_valid), 32'b1000);

        // Read/write hazard on address 5: requester 1 must wait.
        clear_reqs();
        set_req(0, 1'b1, 1'b1, 5'd5, 10'h2C3);
        set_req(1, 1'b1, 1'b0, 5'd5, '0);
        set_req(2, 1'b1, 1'b0, 5'd6, '0);
        #1;
        chk("conf_we1", 32'(ram_we1), 32'd1);
        chk("conf_addr2", 32'(ram_addr2), 32'd6);
        grant("conflict", 4'b0101);
        chk("conflict_rsp", 32'(rsp_valid), 32'b0100);
        clear_reqs();
        set_req(1, 1'b1, 1'b0, 5'd5, '0);
        grant("conflict_retry", 4'b0010);
        chk("retry_rsp", 32'(rsp_valid), 32'b0010);

        // Fairness: everyone reading distinct addresses, rr_ptr currently 2.
        clear_reqs();
        set_req(0, 1'b1, 1'b0, 5'd3, '0);
        set_req(1, 1'b1, 1'b0, 5'd5, '0);
        set_req(2, 1'b1, 1'b0, 5'd7, '0);
        set_req(3, 1'b1, 1'b0, 5'd9, '0);
        for (int c = 0; c < 6; c++) begin
            exp_pair = (c % 2 == 0) ? 4'b1100 : 4'b0011;
            grant("fair", exp_pair);
            chk("fair_rsp", 32'(rsp_valid), 32'(exp_pair));
        end
        clear_reqs();
        tick();

        // Two writes to the same address: only the first in scan order wins.
        set_req(0, 1'b1, 1'b1, 5'd10, 10'h111);
        set_req(1, 1'b1, 1'b1, 5'd10, 10'h222);
        grant("ww_same", 4'b0001);
        clear_reqs();
        set_req(1, 1'b1, 1'b1, 5'd10, 10'h222);
        grant("ww_retry", 4'b0010);
        clear_reqs();
        set_req(2, 1'b1, 1'b0, 5'd10, '0);
        grant("ww_read", 4'b0100);
        chk("ww_rsp", 32'(rsp_valid), 32'b0100);
        clear_reqs();
        tick();

        // Reset lands in the cycle after a read grant: response is dropped.
        set_req(2, 1'b1, 1'b0, 5'd7, '0);
        #1;
        chk("mid_ready", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_reqs();
        @(negedge clk);
        chk("mid_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
        set_req(0, 1'b1, 1'b0, 5'd3, '0);
        set_req(1, 1'b1, 1'b0, 5'd5, '0);
        set_req(3, 1'b1, 1'b0, 5'd9, '0);
        grant("post_rst_ptr0", 4'b0011);
        chk("post_rst_rsp2", 32'(rsp_valid), 32'b0011);
        clear_reqs();
        tick();
        chk("final_rsp", 32'(rsp_valid), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one dual_port_ram (ADDR_WIDTH=5, DATA_WIDTH=10) between N_REQ independent requesters.
- Each cycle, grants up to two requests, one per RAM port, using round-robin priority.
- Prevents same-address hazards between the two ports.
- Returns read data to the originating requester with fixed 1-cycle latency.
- Sits between requester logic and the dual_port_ram instance; it is the sole driver of all RAM port inputs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 5, RAM address width.
- DATA_WIDTH, 10, RAM data width.
- IDX_W, 2, requester index width; must equal clog2(N_REQ).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_we  in  N_REQ  1=write, 0=read.
- req_addr  in  N_REQ*ADDR_WIDTH  flattened addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  N_REQ*DATA_WIDTH  flattened write data.
- req_ready  out  N_REQ  grant; transfer occurs when valid&ready are both high at a clock edge.
- rsp_valid  out  N_REQ  one-cycle pulse, read data valid for requester i.
- rsp_data  out  N_REQ*DATA_WIDTH  flattened read data; meaningful only while the matching rsp_valid is high.
- ram_addr1, ram_addr2  out  ADDR_WIDTH  to RAM addr1/addr2.
- ram_we1, ram_we2  out  1  to RAM we1/we2.
- ram_data1, ram_data2  out  DATA_WIDTH  to RAM data1/data2.
- ram_out1, ram_out2  in  DATA_WIDTH  from RAM out1/out2 (registered, 1-cycle read latency).

Behaviour:
- State: rr_ptr[IDX_W]; per-port registered tags p1_vld, p1_idx, p2_vld, p2_idx (read-in-flight markers).
- Reset low (async):
  - rr_ptr=0, all tags cleared, rsp_valid=0.
  - req_ready=0, ram_we1=ram_we2=0 are forced combinationally while reset is low.
  - ram_addr and ram_data are driven 0.
- Scan order is rr_ptr, rr_ptr+1, … mod N_REQ.
- Port 1 goes to the first valid requester in scan order.
- Port 2 goes to the next valid requester in scan order that does not conflict with port 1.
  - Conflict = same address and at least one of the two is a write.
  - A conflicting requester is skipped; scanning continues past it.
- req_ready is combinational from req_valid, req_we, req_addr and rr_ptr. A requester gets ready only when valid; at most 2 ready bits are high.
- Granted port:
  - ram_addr = requester addr; ram_data = requester wdata; ram_we = requester we.
  - Ungranted port: we=0, addr=0, data=0.
- Read granted on port k in cycle T:
  - p_k_vld=1 and p_k_idx=requester captured at edge T.
  - In cycle T+1: rsp_valid[idx]=1 and rsp_data[idx]=ram_out_k (combinational mux from tag).
  - Writes produce no response.
- A requester may issue back-to-back reads; responses return in grant order, one per cycle.
- rr_ptr update at each edge:
  - Any grant: rr_ptr = (index of last granted requester in scan order) + 1 mod N_REQ.
  - No grant: rr_ptr holds.
- Two writes to different addresses in the same cycle are both granted. Same address: only the first in scan order is granted.
- Read and write to the same address in the same cycle: only the first in scan order is granted; the other retries next cycle with new priority.
- A requester dropping valid without ready: no effect. Requesters must hold addr/we/wdata stable until granted.
- Reset asserted mid-read: the pending rsp_valid is lost (tags cleared); the requester must reissue.
- No internal buffering of requests; throughput is up to 2 accesses per cycle.

Decomposition:
- Package bram_arb_pkg: N_REQ, ADDR_WIDTH, DATA_WIDTH, IDX_W defaults, and the conflict-check function (addr equality plus we OR).
- Sub-module rr_pick:
  - Inputs: request mask, start pointer, exclude mask.
  - Outputs: one-hot grant, index, found flag.
  - Instantiated twice: port 1 with an empty exclude mask; port 2 excluding the port 1 winner and conflicting requesters.
- Top level holds rr_ptr, tags, RAM muxing and response demux.

Test Plan:
- Reset: hold reset=0 with all req_valid=1 -> req_ready=0, ram_we1=ram_we2=0, rsp_valid=0. Release -> first cycle grants req0 (port1) and req1 (port2); rr_ptr=2.
- Write/read: req2 writes 0x155 at addr 7; next cycle req2 reads addr 7 -> req_ready[2]=1 each cycle; the cycle after the read grant, rsp_valid=4'b0100 and rsp_data[2]=0x155.
- Dual read: req0 reads addr 3 (holding 0x0AA) and req3 reads addr 9 (holding 0x3FF) in the same cycle -> both granted; next cycle rsp_valid=4'b1001 with the correct data per requester.
- Conflict: rr_ptr=0; req0 writes addr 5; req1 reads addr 5; req2 reads addr 6 -> grants req0 (port1) and req2 (port2); req1 granted next cycle with rr_ptr=3 (reads the new value).
- Fairness: all 4 requesters continuously valid reading distinct addresses -> grant pairs {0,1},{2,3},{0,1}…; each requester served once per 2 cycles.
- Reset mid-read: read granted at cycle T, reset asserted during T+1 -> rsp_valid stays 0; after release the tags are clear and no spurious response appears.
